// File: rtl/bus_slave_regfile_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_regfile_pkg
// Shared definitions for the generic bus slave responder: bus widths,
// active-low strobe levels, read/write encoding and the FSM state type.
// -----------------------------------------------------------------------------
package bus_slave_regfile_pkg;

    localparam int WORD_ADDR_W = 30;    // word address bus width
    localparam int WORD_DATA_W = 32;    // word data bus width
    localparam int WAIT_W      = 4;     // wait-state counter width (0..15)

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;   // active-low asserted level
    localparam logic DISABLE_ = 1'b1;   // active-low idle level

    typedef enum logic [1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_RESP = 2'd2
    } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_regfile_regs.sv
// -----------------------------------------------------------------------------
// bus_slave_regfile_regs
// NUM_REGS x 32-bit register array, one synchronous write port and one
// combinational read port, cleared by the asynchronous active-low reset.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset, clears every register
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module bus_slave_regfile_regs
    import bus_slave_regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [WORD_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [WORD_DATA_W-1:0] rdata
);

    logic [WORD_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/bus_slave_regfile.sv
// -----------------------------------------------------------------------------
// bus_slave_regfile
// Generic bus slave responder: decodes a master request, holds a
// NUM_REGS x 32-bit register file and answers with a one-cycle rdy_ pulse
// after 1+WAIT_CYCLES cycles.
//
// Handshake: a request is accepted on an edge where the FSM is IDLE with
// cs_ and as_ both low. The master holds the request until it sees rdy_ low;
// rdy_ is low for exactly one cycle per accepted access and rd_data is only
// non-zero in that cycle. Dropping cs_ during the wait states aborts.
//
// Optional feature (macro BUS_SLAVE_IRQ_EN): adds output irq, set by a write
// commit to the last register, cleared by a read of the last register.
//
// Ports:
//   clk        in   bus clock
//   reset      in   asynchronous active-low reset
//   cs_, as_   in   chip select / address strobe, active low
//   rw         in   READ (1) / WRITE (0)
//   addr       in   word address; only the low index bits are decoded
//   wr_data    in   write data
//   rd_data    out  read data, registered, zero outside the rdy_ cycle
//   rdy_       out  ready pulse, active low, registered
//   irq        out  (BUS_SLAVE_IRQ_EN only) interrupt, active high
//   state_dbg  out  current FSM state, for observation
// -----------------------------------------------------------------------------
module bus_slave_regfile
    import bus_slave_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_,
`ifdef BUS_SLAVE_IRQ_EN
    output logic                   irq,
`endif
    output bus_slv_state_e         state_dbg
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    bus_slv_state_e         state, state_next;
    logic [WAIT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]       idx_q;
    logic                   rw_q;
    logic [WORD_DATA_W-1:0] wdata_q;

    logic                   accept;
    logic                   op_rw;
    logic [IDX_W-1:0]       op_idx;
    logic [WORD_DATA_W-1:0] op_data;
    logic                   commit;
    logic [WORD_DATA_W-1:0] reg_rdata;

    // Upper address bits alias onto the register array by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[WORD_ADDR_W-1:IDX_W];

    assign accept    = (state == BUS_SLV_IDLE) && (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign state_dbg = state;

    // With zero wait states the write commits on the accept edge itself, so
    // the operands come straight from the bus; otherwise from the latches.
    assign op_rw   = (state == BUS_SLV_IDLE) ? rw : rw_q;
    assign op_idx  = (state == BUS_SLV_IDLE) ? addr[IDX_W-1:0] : idx_q;
    assign op_data = (state == BUS_SLV_IDLE) ? wr_data : wdata_q;
    assign commit  = (state_next == BUS_SLV_RESP) && (op_rw == WRITE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            BUS_SLV_IDLE: begin
                if (accept) begin
                    cnt_next   = WAIT_W'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES == 0) ? BUS_SLV_RESP : BUS_SLV_WAIT;
                end
            end
            BUS_SLV_WAIT: begin
                if (cs_ == DISABLE_) begin
                    cnt_next   = '0;
                    state_next = BUS_SLV_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == WAIT_W'(1)) begin
                        state_next = BUS_SLV_RESP;
                    end
                end
            end
            BUS_SLV_RESP: begin
                cnt_next   = '0;
                state_next = BUS_SLV_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = BUS_SLV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= BUS_SLV_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            rw_q    <= READ;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                idx_q   <= addr[IDX_W-1:0];
                rw_q    <= rw;
                wdata_q <= wr_data;
            end
        end
    end

    // Outputs are loaded while in RESP, so the pulse appears in the cycle
    // after RESP and no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_    <= DISABLE_;
            rd_data <= '0;
        end else begin
            rdy_    <= (state == BUS_SLV_RESP) ? ENABLE_ : DISABLE_;
            rd_data <= ((state == BUS_SLV_RESP) && (rw_q == READ)) ? reg_rdata : '0;
        end
    end

`ifdef BUS_SLAVE_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (commit && (op_idx == LAST_IDX)) begin
            irq <= 1'b1;
        end else if ((state == BUS_SLV_RESP) && (rw_q == READ) && (idx_q == LAST_IDX)) begin
            irq <= 1'b0;
        end
    end
`endif

    bus_slave_regfile_regs #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regs (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .waddr (op_idx),
        .wdata (op_data),
        .raddr (idx_q),
        .rdata (reg_rdata)
    );

endmodule

// File: tb/tb_bus_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_regfile
// Four responders with WAIT_CYCLES = 0..3 share clock and reset; instance k
// has WAIT_CYCLES = k, so its expected latency is 1+k cycles.
// -----------------------------------------------------------------------------
module tb_bus_slave_regfile;
    import bus_slave_regfile_pkg::*;

    localparam int N_DUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic                   cs_v    [N_DUT];
    logic                   as_v    [N_DUT];
    logic                   rw_v    [N_DUT];
    logic [WORD_ADDR_W-1:0] addr_v  [N_DUT];
    logic [WORD_DATA_W-1:0] wr_v    [N_DUT];
    logic [WORD_DATA_W-1:0] rd_v    [N_DUT];
    logic                   rdy_v   [N_DUT];
    bus_slv_state_e         dbg_v   [N_DUT];
`ifdef BUS_SLAVE_IRQ_EN
    logic                   irq_v   [N_DUT];
`endif

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        bus_slave_regfile #(
            .NUM_REGS    (8),
            .WAIT_CYCLES (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cs_       (cs_v[g]),
            .as_       (as_v[g]),
            .rw        (rw_v[g]),
            .addr      (addr_v[g]),
            .wr_data   (wr_v[g]),
            .rd_data   (rd_v[g]),
            .rdy_      (rdy_v[g]),
`ifdef BUS_SLAVE_IRQ_EN
            .irq       (irq_v[g]),
`endif
            .state_dbg (dbg_v[g])
        );
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        for (int k = 0; k < N_DUT; k++) begin
            cs_v[k]   = 1'b1;
            as_v[k]   = 1'b1;
            rw_v[k]   = READ;
            addr_v[k] = '0;
            wr_v[k]   = '0;
        end
    endtask

    // One full access: returns the data seen in the rdy_ cycle and the number
    // of edges after the accept edge until rdy_ was seen (-1 on timeout).
    task automatic do_access(input int k, input logic r, input logic [29:0] a,
                             input logic [31:0] d, output logic [31:0] rdata,
                             output int lat);
        bit seen;
        @(negedge clk);
        cs_v[k] = 1'b0; as_v[k] = 1'b0; rw_v[k] = r; addr_v[k] = a; wr_v[k] = d;
        @(posedge clk);
        lat = -1; rdata = '0; seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (rdy_v[k] == 1'b0) begin
                    lat = c; rdata = rd_v[k]; seen = 1'b1;
                end
            end
        end
        cs_v[k] = 1'b1; as_v[k] = 1'b1;
        @(posedge clk); #1;
        check("pulse_end_rdy", 32'(rdy_v[k]), 32'd1);
        check("pulse_end_rd_data", rd_v[k], 32'h0);
    endtask

    typedef struct {
        int          k;
        logic        r;
        logic [29:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] rdata;
    int          lat;
    int          got_q [$];
    int          exp_q [$];
    int          lows;

    initial begin
        idle_bus();

        vecs[0] = '{1, WRITE, 30'h3,  32'hDEADBEEF, 32'h0,        2};
        vecs[1] = '{1, READ,  30'h3,  32'h0,        32'hDEADBEEF, 2};
        vecs[2] = '{0, WRITE, 30'h0A, 32'h12345678, 32'h0,        1};
        vecs[3] = '{0, READ,  30'h02, 32'h0,        32'h12345678, 1};
        vecs[4] = '{0, READ,  30'h0A, 32'h0,        32'h12345678, 1};
        vecs[5] = '{2, WRITE, 30'h6,  32'hCAFEF00D, 32'h0,        3};
        vecs[6] = '{2, READ,  30'h1E, 32'h0,        32'hCAFEF00D, 3};
        vecs[7] = '{3, READ,  30'h5,  32'h0,        32'h0,        4};

        // Reset held 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check("reset_rdy", 32'(rdy_v[k]), 32'd1);
            check("reset_rd_data", rd_v[k], 32'h0);
        end
`ifdef BUS_SLAVE_IRQ_EN
        check("reset_irq", 32'(irq_v[1]), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            do_access(1, READ, 30'(i), 32'h0, rdata, lat);
            check("reset_read", rdata, 32'h0);
        end

        // Table-driven accesses.
        for (int v = 0; v < 8; v++) begin
            do_access(vecs[v].k, vecs[v].r, vecs[v].a, vecs[v].d, rdata, lat);
            check("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
            check("vec_rd_data", rdata, vecs[v].exp_rd);
        end

        // Held strobe on the 2-wait-state slave: pulses after edges 3 and 7.
        @(negedge clk);
        cs_v[2] = 1'b0; as_v[2] = 1'b0; rw_v[2] = READ; addr_v[2] = 30'h1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (rdy_v[2] == 1'b0) got_q.push_back(e);
        end
        cs_v[2] = 1'b1; as_v[2] = 1'b1;
        exp_q = '{3, 7};
        check("held_pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check("held_pulse_edge", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFFFFFF,
                  32'(exp_q[i]));
        end
        repeat (2) @(posedge clk); #1;
        check("held_release_idle", 32'(dbg_v[2]), 32'(BUS_SLV_IDLE));

        // Abort: drop cs_ one cycle into a 3-wait-state write.
        @(negedge clk);
        cs_v[3] = 1'b0; as_v[3] = 1'b0; rw_v[3] = WRITE; addr_v[3] = 30'h5;
        wr_v[3] = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        cs_v[3] = 1'b1; as_v[3] = 1'b1;
        lows = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rdy_v[3] == 1'b0) lows++;
        end
        check("abort_no_rdy", 32'(lows), 32'd0);
        check("abort_idle", 32'(dbg_v[3]), 32'(BUS_SLV_IDLE));
        do_access(3, READ, 30'h5, 32'h0, rdata, lat);
        check("abort_old_value", rdata, 32'h0);
        check("abort_read_latency", 32'(lat), 32'd4);

`ifdef BUS_SLAVE_IRQ_EN
        do_access(1, WRITE, 30'h7, 32'h00000077, rdata, lat);
        check("irq_set", 32'(irq_v[1]), 32'd1);
        do_access(1, READ, 30'h1, 32'h0, rdata, lat);
        check("irq_hold", 32'(irq_v[1]), 32'd1);
        do_access(1, READ, 30'h7, 32'h0, rdata, lat);
        check("irq_read_last_data", rdata, 32'h00000077);
        check("irq_clear", 32'(irq_v[1]), 32'd0);
        do_access(1, WRITE, 30'h7, 32'h00000001, rdata, lat);
        check("irq_set_again", 32'(irq_v[1]), 32'd1);
`endif

        // Reset asserted in the middle of a 3-wait-state write.
        @(negedge clk);
        cs_v[3] = 1'b0; as_v[3] = 1'b0; rw_v[3] = WRITE; addr_v[3] = 30'h4;
        wr_v[3] = 32'h0BADF00D;
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_reset_wait", 32'(dbg_v[3]), 32'(BUS_SLV_WAIT));
        reset = 1'b0;
        #1;
        check("midreset_rdy", 32'(rdy_v[3]), 32'd1);
        check("midreset_idle", 32'(dbg_v[3]), 32'(BUS_SLV_IDLE));
`ifdef BUS_SLAVE_IRQ_EN
        check("midreset_irq", 32'(irq_v[1]), 32'd0);
`endif
        cs_v[3] = 1'b1; as_v[3] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        do_access(3, READ, 30'h4, 32'h0, rdata, lat);
        check("midreset_write_lost", rdata, 32'h0);
        do_access(1, READ, 30'h3, 32'h0, rdata, lat);
        check("midreset_regs_cleared", rdata, 32'h0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
